// File: rtl/register_file_if.sv
// ----------------------------------------------------------------------------
// register_file_if
//   Bundle between the register file and its clients: the dispatcher (operand
//   lookup plus rename install) and the reorder buffer (commit and rollback).
//
//   Signal groups:
//     dispatcher query   : rs1_from_dsp / rs2_from_dsp -> Q1/V1, Q2/V2
//     dispatcher rename  : ena_from_dsp, rd_from_dsp, rob_id_from_dsp
//     ROB commit stream  : commit_flag, rd_from_rob, Q_from_rob, V_from_rob
//     ROB flush          : rollback_flag
//
//   Handshake semantics: ena_from_dsp, commit_flag and rollback_flag are
//   valid-only strobes with no ready back-pressure. They take effect on a
//   rising clk edge when the register file's global rdy is high. While rdy is
//   low they are ignored and all state holds. The query path is combinational
//   and always live.
//
//   Modports:
//     master : client side (dispatcher + ROB), drives requests.
//     slave  : register file side, returns the operand lookups.
// ----------------------------------------------------------------------------
interface register_file_if #(
    parameter int REG_POS_W = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_ID_W  = 5
);
    logic [REG_POS_W-1:0] rs1_from_dsp;
    logic [REG_POS_W-1:0] rs2_from_dsp;
    logic [ROB_ID_W-1:0]  Q1_to_dsp;
    logic [ROB_ID_W-1:0]  Q2_to_dsp;
    logic [DATA_W-1:0]    V1_to_dsp;
    logic [DATA_W-1:0]    V2_to_dsp;

    logic                 ena_from_dsp;
    logic [REG_POS_W-1:0] rd_from_dsp;
    logic [ROB_ID_W-1:0]  rob_id_from_dsp;

    logic                 commit_flag;
    logic [REG_POS_W-1:0] rd_from_rob;
    logic [ROB_ID_W-1:0]  Q_from_rob;
    logic [DATA_W-1:0]    V_from_rob;

    logic                 rollback_flag;

    modport master (
        output rs1_from_dsp, rs2_from_dsp,
        output ena_from_dsp, rd_from_dsp, rob_id_from_dsp,
        output commit_flag, rd_from_rob, Q_from_rob, V_from_rob,
        output rollback_flag,
        input  Q1_to_dsp, Q2_to_dsp, V1_to_dsp, V2_to_dsp
    );

    modport slave (
        input  rs1_from_dsp, rs2_from_dsp,
        input  ena_from_dsp, rd_from_dsp, rob_id_from_dsp,
        input  commit_flag, rd_from_rob, Q_from_rob, V_from_rob,
        input  rollback_flag,
        output Q1_to_dsp, Q2_to_dsp, V1_to_dsp, V2_to_dsp
    );
endinterface

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Architectural register file with a rename tag per register. A tag of 0
//   means the register value is architecturally valid. A nonzero tag is
//   (ROB index + 1) of the youngest in-flight writer.
//
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset, clears all values and tags
//     rdy  : global ready; low freezes all state (query stays live)
//     bus  : register_file_if.slave (dispatcher query/rename, ROB commit and
//            rollback)
//
//   x0 is never written, so it reads as value 0 with tag 0 forever.
// ----------------------------------------------------------------------------
module register_file #(
    parameter int REG_NUM   = 32,
    parameter int REG_POS_W = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    register_file_if.slave   bus
);

    logic [DATA_W-1:0]   value_q [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q   [REG_NUM];

    // The commit clears the tag only if it comes from the youngest writer. If a
    // younger rename exists, its tag differs from Q_from_rob and stays in place.
    logic commit_live;
    logic commit_tag_match;
    logic rename_live;

    always_comb begin
        commit_live      = bus.commit_flag && (bus.rd_from_rob != '0);
        commit_tag_match = commit_live && (tag_q[bus.rd_from_rob] == bus.Q_from_rob);
        rename_live      = bus.ena_from_dsp && (bus.rd_from_dsp != '0) && !bus.rollback_flag;
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            // Entry 0 is left out of the loop, so it keeps its reset value.
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_live && (bus.rd_from_rob == REG_POS_W'(i))) begin
                    value_q[i] <= bus.V_from_rob;
                end

                if (bus.rollback_flag) begin
                    tag_q[i] <= '0;
                end else if (rename_live && (bus.rd_from_dsp == REG_POS_W'(i))) begin
                    // A rename wins over a same-cycle tag clear on this register.
                    tag_q[i] <= bus.rob_id_from_dsp;
                end else if (commit_tag_match && (bus.rd_from_rob == REG_POS_W'(i))) begin
                    tag_q[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand lookup. A commit whose tag matches bypasses the array, so the
    // dispatcher sees the value in the same cycle it retires. The lookup uses
    // the mapping before any same-cycle rename, so an instruction that reads
    // its own rd gets the older producer.
    // ------------------------------------------------------------------
    function automatic logic [ROB_ID_W+DATA_W-1:0] lookup(input logic [REG_POS_W-1:0] rs);
        logic [ROB_ID_W-1:0] q;
        logic [DATA_W-1:0]   v;
        q = '0;
        v = '0;
        if (rs != '0) begin
            if (bus.commit_flag && (bus.rd_from_rob == rs) && (tag_q[rs] == bus.Q_from_rob)) begin
                v = bus.V_from_rob;
            end else begin
                q = tag_q[rs];
                v = value_q[rs];
            end
        end
        return {q, v};
    endfunction

    always_comb begin
        {bus.Q1_to_dsp, bus.V1_to_dsp} = lookup(bus.rs1_from_dsp);
        {bus.Q2_to_dsp, bus.V2_to_dsp} = lookup(bus.rs2_from_dsp);
    end

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Randomised plus directed stimulus for register_file. A reference model made
//   of plain arrays predicts each cycle's operand lookup. The prediction goes
//   into exp_q, and a negedge monitor pops each entry and compares it.
// ----------------------------------------------------------------------------
module tb_register_file;

    localparam int REG_NUM   = 32;
    localparam int REG_POS_W = 5;
    localparam int DATA_W    = 32;
    localparam int ROB_ID_W  = 5;
    localparam int W         = 2 * (ROB_ID_W + DATA_W);

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    always #5 clk = ~clk;

    register_file_if #(.REG_POS_W(REG_POS_W), .DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) bus ();

    register_file #(
        .REG_NUM  (REG_NUM),
        .REG_POS_W(REG_POS_W),
        .DATA_W   (DATA_W),
        .ROB_ID_W (ROB_ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    // ------------------------------------------------------------------
    // Reference model: the architectural state as arrays
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   m_val [REG_NUM];
    logic [ROB_ID_W-1:0] m_tag [REG_NUM];

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [ROB_ID_W+DATA_W-1:0] model_query(input int rs);
        if (rs == 0) return '0;
        if (bus.commit_flag && (int'(bus.rd_from_rob) == rs) && (m_tag[rs] == bus.Q_from_rob))
            return {{ROB_ID_W{1'b0}}, bus.V_from_rob};
        return {m_tag[rs], m_val[rs]};
    endfunction

    task automatic model_update();
        int crd;
        int drd;
        logic clear_ok;
        if (!rdy) return;
        crd = int'(bus.rd_from_rob);
        drd = int'(bus.rd_from_dsp);
        clear_ok = 1'b0;
        if (bus.commit_flag && crd != 0) begin
            clear_ok   = (m_tag[crd] == bus.Q_from_rob);
            m_val[crd] = bus.V_from_rob;
        end
        if (bus.rollback_flag) begin
            for (int i = 0; i < REG_NUM; i++) m_tag[i] = '0;
        end else begin
            if (clear_ok) m_tag[crd] = '0;
            if (bus.ena_from_dsp && drd != 0) m_tag[drd] = bus.rob_id_from_dsp;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        bus.rs1_from_dsp    = '0;
        bus.rs2_from_dsp    = '0;
        bus.ena_from_dsp    = 1'b0;
        bus.rd_from_dsp     = '0;
        bus.rob_id_from_dsp = '0;
        bus.commit_flag     = 1'b0;
        bus.rd_from_rob     = '0;
        bus.Q_from_rob      = '0;
        bus.V_from_rob      = '0;
        bus.rollback_flag   = 1'b0;
        rdy                 = 1'b1;
    endtask

    // Issue the currently driven inputs for one cycle. The prediction is made
    // against the pre-edge model state, and then the model is advanced.
    task automatic step();
        exp_q.push_back({model_query(int'(bus.rs1_from_dsp)), model_query(int'(bus.rs2_from_dsp))});
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
    endtask

    task automatic dispatch(input int rd, input int rob);
        bus.ena_from_dsp    = 1'b1;
        bus.rd_from_dsp     = REG_POS_W'(rd);
        bus.rob_id_from_dsp = ROB_ID_W'(rob);
    endtask

    task automatic commit(input int rd, input int q, input logic [DATA_W-1:0] v);
        bus.commit_flag = 1'b1;
        bus.rd_from_rob = REG_POS_W'(rd);
        bus.Q_from_rob  = ROB_ID_W'(q);
        bus.V_from_rob  = v;
    endtask

    task automatic query(input int rs1, input int rs2);
        bus.rs1_from_dsp = REG_POS_W'(rs1);
        bus.rs2_from_dsp = REG_POS_W'(rs2);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    task automatic check_field(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_field("Q1", DATA_W'(bus.Q1_to_dsp), DATA_W'(e[W-1 -: ROB_ID_W]));
            check_field("V1", bus.V1_to_dsp, e[W-ROB_ID_W-1 -: DATA_W]);
            check_field("Q2", DATA_W'(bus.Q2_to_dsp), DATA_W'(e[ROB_ID_W+DATA_W-1 -: ROB_ID_W]));
            check_field("V2", bus.V2_to_dsp, e[DATA_W-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int budget;
        do_reset();

        // Reset state; a dispatch to x0 leaves x0 unrenamed.
        query(7, 0); dispatch(0, 3); step(); idle_inputs();
        query(0, 7); step();

        // Rename, then a commit bypass, then the committed value from the array.
        dispatch(5, 4); step(); idle_inputs();
        query(5, 0); step();
        query(5, 0); commit(5, 4, 32'hDEADBEEF); step(); idle_inputs();
        query(5, 5); step();

        // A stale commit writes the value but leaves the younger tag alone.
        dispatch(6, 2); step();
        dispatch(6, 7); step(); idle_inputs();
        query(6, 0); commit(6, 2, 32'h11); step(); idle_inputs();
        query(6, 6); step();

        // A commit and a rename of the same rd in the same cycle.
        dispatch(9, 3); step(); idle_inputs();
        query(9, 9); commit(9, 3, 32'h99); dispatch(9, 8); step(); idle_inputs();
        query(9, 0); step();

        // Rollback with a same-cycle commit and dispatch.
        dispatch(1, 10); step();
        dispatch(2, 11); step();
        dispatch(3, 12); step(); idle_inputs();
        query(1, 2); commit(1, 10, 32'h40); dispatch(4, 13); bus.rollback_flag = 1'b1; step();
        idle_inputs();
        query(1, 4); step();
        query(2, 3); step();

        // rdy low freezes state; the first ready cycle applies the update.
        dispatch(10, 5); step(); idle_inputs();
        for (int c = 0; c < 3; c++) begin
            query(10, 11); commit(10, 5, 32'h77); dispatch(11, 6); rdy = 1'b0; step();
        end
        query(11, 10); step();
        rdy = 1'b1; query(10, 11); step(); idle_inputs();
        query(10, 11); step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int crd;
            idle_inputs();
            query($urandom_range(0, REG_NUM-1), $urandom_range(0, REG_NUM-1));
            if ($urandom_range(0, 1) == 1)
                dispatch($urandom_range(0, REG_NUM-1), $urandom_range(1, (1 << ROB_ID_W) - 1));
            if ($urandom_range(0, 1) == 1) begin
                crd = $urandom_range(0, REG_NUM-1);
                if ($urandom_range(0, 1) == 1)
                    commit(crd, int'(m_tag[crd]), $urandom());
                else
                    commit(crd, $urandom_range(0, (1 << ROB_ID_W) - 1), $urandom());
                // Steer the lookup toward the committing register sometimes.
                if ($urandom_range(0, 2) == 0) bus.rs1_from_dsp = REG_POS_W'(crd);
            end
            bus.rollback_flag = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            step();
        end
        idle_inputs();

        // Let the monitor drain the queue within a bounded number of cycles.
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
